ram_arbiter: RTL and testbench

Shares the single external RAM port between the IO-controller download path and the CPU. Download write strobes are single-cycle pulses with no back-pressure, so they are buffered in a small write FIFO and drained into RAM. CPU accesses use a req/ack handshake. The block sits between the download/erase write port, the CPU bus adapter and the RAM controller, all on the system clock.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter bus bundle: download write port, CPU req/ack port and RAM controller port.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface ram_arbiter_if #(
    parameter int unsigned AW = 25
);
    // download / erase write port
    logic          io_wr;
    logic [AW-1:0] io_a;
    logic [7:0]    io_d;
    logic          io_busy;
    logic          io_ovf;

    // CPU bus adapter port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [7:0]    cpu_d;
    logic [7:0]    cpu_q;
    logic          cpu_ack;

    // RAM controller port
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic          ram_oe;
    logic [7:0]    ram_q;

    modport slave (
        input  io_wr, io_a, io_d,
        output io_busy, io_ovf,
        input  cpu_req, cpu_we, cpu_a, cpu_d,
        output cpu_q, cpu_ack,
        output ram_a, ram_d, ram_we, ram_oe,
        input  ram_q
    );

    modport master (
        output io_wr, io_a, io_d,
        input  io_busy, io_ovf,
        output cpu_req, cpu_we, cpu_a, cpu_d,
        input  cpu_q, cpu_ack,
        input  ram_a, ram_d, ram_we, ram_oe,
        output ram_q
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between a buffered download write stream and CPU req/ack accesses.
// Download strobes go through a DEPTH-entry write FIFO; IO has priority over the CPU.
// Optional macro RAM_ARB_FAIR_EN: after BURST IO grants with a CPU request pending, the CPU is served next.
module ram_arbiter #(
    parameter int unsigned AW    = 25,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = PW + 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IO   = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    wr_entry_t       fifo_mem [DEPTH];
    wr_entry_t       head;

    logic [AW-1:0]   ram_a_q, ram_a_d;
    logic [DW-1:0]   ram_d_q, ram_d_d;
    logic            ram_we_q, ram_we_d;
    logic            ram_oe_q, ram_oe_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic [DW-1:0]   cpu_q_q, cpu_q_d;
    logic            io_busy_q, io_busy_d;
    logic            io_ovf_q, io_ovf_d;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            io_grant;
    logic            cpu_grant;
    logic            fair_ovr;
    logic            cpu_pending;

    // A request is eligible only outside its own ack cycle, so it is never served twice.
    assign cpu_pending = bus.cpu_req && !cpu_ack_q;
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == NW'(DEPTH));
    assign head        = fifo_mem[rd_ptr_q];

`ifdef RAM_ARB_FAIR_EN
    localparam int unsigned FW = $clog2(BURST + 1);

    logic [FW-1:0] fair_q, fair_d;

    // Fairness override: CPU wins the next grant once BURST IO grants passed it by.
    assign fair_ovr = (fair_q >= FW'(BURST)) && cpu_pending;

    // Count IO grants made while the CPU waits; clear on CPU grant or when no request is up.
    always_comb begin
        fair_d = fair_q;
        if (!bus.cpu_req || cpu_grant) begin
            fair_d = '0;
        end else if (io_grant && (fair_q < FW'(BURST))) begin
            fair_d = fair_q + FW'(1);
        end
    end

    // Fairness counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fair_q <= '0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    logic unused_fair;

    // Strict IO priority: no override, grant strobes and BURST have no consumer.
    assign fair_ovr    = 1'b0;
    assign unused_fair = ^{32'(BURST), io_grant, cpu_grant};
`endif

    // Arbitration FSM: grants in IDLE, LAT-cycle accesses, always back through IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_a_d   = ram_a_q;
        ram_d_d   = ram_d_q;
        ram_we_d  = 1'b0;
        ram_oe_d  = 1'b0;
        cpu_ack_d = 1'b0;
        cpu_q_d   = cpu_q_q;
        pop       = 1'b0;
        io_grant  = 1'b0;
        cpu_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !fair_ovr) begin
                    state_d  = S_IO;
                    cnt_d    = '0;
                    ram_a_d  = head.addr;
                    ram_d_d  = head.data;
                    ram_we_d = 1'b1;
                    io_grant = 1'b1;
                end else if (cpu_pending) begin
                    state_d   = S_CPU;
                    cnt_d     = '0;
                    ram_a_d   = bus.cpu_a;
                    ram_d_d   = bus.cpu_d;
                    ram_we_d  = bus.cpu_we;
                    ram_oe_d  = !bus.cpu_we;
                    cpu_grant = 1'b1;
                end
            end
            S_IO: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    ram_we_d = 1'b1;
                end
            end
            S_CPU: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d   = S_IDLE;
                    cpu_ack_d = 1'b1;
                    if (!bus.cpu_we) begin
                        cpu_q_d = bus.ram_q;
                    end
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    ram_we_d = bus.cpu_we;
                    ram_oe_d = !bus.cpu_we;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write FIFO bookkeeping: a full FIFO still accepts a strobe in its pop cycle.
    always_comb begin
        push     = bus.io_wr && (!fifo_full || pop);
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        io_busy_d = (count_d != '0) || (state_d == S_IO);
        io_ovf_d  = io_ovf_q || (bus.io_wr && !push);
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{addr: bus.io_a, data: bus.io_d};
        end
    end

    // State, FIFO pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ram_a_q   <= '0;
            ram_d_q   <= '0;
            ram_we_q  <= 1'b0;
            ram_oe_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            cpu_q_q   <= '0;
            io_busy_q <= 1'b0;
            io_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ram_a_q   <= ram_a_d;
            ram_d_q   <= ram_d_d;
            ram_we_q  <= ram_we_d;
            ram_oe_q  <= ram_oe_d;
            cpu_ack_q <= cpu_ack_d;
            cpu_q_q   <= cpu_q_d;
            io_busy_q <= io_busy_d;
            io_ovf_q  <= io_ovf_d;
        end
    end

    assign bus.ram_a   = ram_a_q;
    assign bus.ram_d   = ram_d_q;
    assign bus.ram_we  = ram_we_q;
    assign bus.ram_oe  = ram_oe_q;
    assign bus.cpu_ack = cpu_ack_q;
    assign bus.cpu_q   = cpu_q_q;
    assign bus.io_busy = io_busy_q;
    assign bus.io_ovf  = io_ovf_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (AW=25, LAT=2, DEPTH=4, BURST=8).
// Expectations for the CPU-starvation step follow RAM_ARB_FAIR_EN when it is defined.
module tb_ram_arbiter;

    localparam int unsigned AW    = 25;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BURST = 8;

    logic clk = 1'b0;
    logic reset;

    ram_arbiter_if #(.AW(AW)) bus ();

    ram_arbiter #(
        .AW   (AW),
        .LAT  (LAT),
        .DEPTH(DEPTH),
        .BURST(BURST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Access log: every rising ram_we records {addr,data}; reads and acks are counted.
    logic [AW+7:0] wq [$];
    logic          we_prev = 1'b0;
    logic          oe_prev = 1'b0;
    int            n_rd = 0;
    int            n_ack = 0;
    int            ack_wsnap = 0;

    always @(negedge clk) begin
        if (bus.ram_we && !we_prev) wq.push_back({bus.ram_a, bus.ram_d});
        if (bus.ram_oe && !oe_prev) n_rd = n_rd + 1;
        if (bus.cpu_ack) begin
            n_ack     = n_ack + 1;
            ack_wsnap = wq.size();
        end
        we_prev = bus.ram_we;
        oe_prev = bus.ram_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_we"},  64'(bus.ram_we),  64'd0);
        chk({tag, "_ram_oe"},  64'(bus.ram_oe),  64'd0);
        chk({tag, "_ram_a"},   64'(bus.ram_a),   64'd0);
        chk({tag, "_ram_d"},   64'(bus.ram_d),   64'd0);
        chk({tag, "_cpu_ack"}, 64'(bus.cpu_ack), 64'd0);
        chk({tag, "_cpu_q"},   64'(bus.cpu_q),   64'd0);
        chk({tag, "_io_busy"}, 64'(bus.io_busy), 64'd0);
        chk({tag, "_io_ovf"},  64'(bus.io_ovf),  64'd0);
    endtask

    initial begin
        int            base;
        int            acks0;
        int            rds0;
        int            exp_snap;
        logic          ack_prev;
        logic [AW+7:0] e;

        reset       = 1'b1;
        bus.io_wr   = 1'b0;
        bus.io_a    = '0;
        bus.io_d    = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.cpu_a   = '0;
        bus.cpu_d   = '0;
        bus.ram_q   = '0;

        // ---- reset state
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // ---- single download write
        bus.io_wr = 1'b1;
        bus.io_a  = AW'(32'h200000);
        bus.io_d  = 8'hA5;
        tick();                                   // t+1
        bus.io_wr = 1'b0;
        chk("io1_busy_t1", 64'(bus.io_busy), 64'd1);
        chk("io1_we_t1",   64'(bus.ram_we),  64'd0);
        tick();                                   // t+2
        chk("io1_we_t2", 64'(bus.ram_we), 64'd1);
        chk("io1_a_t2",  64'(bus.ram_a),  64'h200000);
        chk("io1_d_t2",  64'(bus.ram_d),  64'hA5);
        tick();                                   // t+3
        chk("io1_we_t3", 64'(bus.ram_we), 64'd1);
        chk("io1_a_t3",  64'(bus.ram_a),  64'h200000);
        tick();                                   // t+4
        chk("io1_we_t4",   64'(bus.ram_we),  64'd0);
        chk("io1_busy_t4", 64'(bus.io_busy), 64'd0);
        chk("io1_no_ack",  64'(n_ack),       64'd0);
        chk("io1_nwrites", 64'(wq.size()),   64'd1);

        // ---- CPU read, request held through the ack cycle
        tick();
        rds0        = n_rd;
        bus.ram_q   = 8'h3C;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.cpu_a   = AW'(32'h000100);
        tick();                                   // t+1
        chk("rd_oe_t1", 64'(bus.ram_oe), 64'd1);
        chk("rd_we_t1", 64'(bus.ram_we), 64'd0);
        chk("rd_a_t1",  64'(bus.ram_a),  64'h100);
        tick();                                   // t+2
        chk("rd_oe_t2",  64'(bus.ram_oe),  64'd1);
        chk("rd_ack_t2", 64'(bus.cpu_ack), 64'd0);
        tick();                                   // t+3: ack cycle, req still high
        chk("rd_oe_t3",  64'(bus.ram_oe),  64'd0);
        chk("rd_ack_t3", 64'(bus.cpu_ack), 64'd1);
        chk("rd_q_t3",   64'(bus.cpu_q),   64'h3C);
        bus.ram_q = 8'h00;
        tick();                                   // t+4
        bus.cpu_req = 1'b0;
        chk("rd_ack_t4", 64'(bus.cpu_ack), 64'd0);
        chk("rd_oe_t4",  64'(bus.ram_oe),  64'd0);
        tick();
        tick();
        chk("rd_q_hold", 64'(bus.cpu_q),  64'h3C);
        chk("rd_once",   64'(n_rd - rds0), 64'd1);

        // ---- six back-to-back strobes: five stored, sixth dropped
        base = wq.size();
        for (int i = 0; i < 6; i++) begin
            bus.io_wr = 1'b1;
            bus.io_a  = AW'(32'h10 + i);
            bus.io_d  = 8'(8'h50 + i);
            tick();
        end
        bus.io_wr = 1'b0;
        chk("ovf_set", 64'(bus.io_ovf), 64'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("ovf_nwrites", 64'(wq.size() - base), 64'd5);
        for (int i = 0; i < 5; i++) begin
            e = {AW'(32'h10 + i), 8'(8'h50 + i)};
            chk($sformatf("ovf_entry%0d", i), 64'(wq[base + i]), 64'(e));
        end
        chk("ovf_sticky", 64'(bus.io_ovf),  64'd1);
        chk("ovf_idle",   64'(bus.io_busy), 64'd0);
        reset = 1'b1;
        tick();
        chk("ovf_cleared", 64'(bus.io_ovf), 64'd0);
        reset = 1'b0;
        tick();

        // ---- strobe on a pop while full is accepted
        base = wq.size();
        for (int c = 0; c < 7; c++) begin
            bus.io_wr = (c != 5);
            bus.io_a  = AW'(32'h40 + c);
            bus.io_d  = 8'(8'h90 + c);
            tick();
        end
        bus.io_wr = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        chk("full_pop_ovf",     64'(bus.io_ovf),          64'd0);
        chk("full_pop_nwrites", 64'(wq.size() - base),    64'd6);
        for (int i = 0; i < 6; i++) begin
            int k;
            k = (i < 5) ? i : 6;
            e = {AW'(32'h40 + k), 8'(8'h90 + k)};
            chk($sformatf("full_pop_entry%0d", i), 64'(wq[base + i]), 64'(e));
        end

        // ---- IO stream every 3 cycles with a CPU read waiting
        base     = wq.size();
        acks0    = n_ack;
        ack_prev = 1'b0;
        bus.ram_q = 8'h11;
`ifdef RAM_ARB_FAIR_EN
        exp_snap = 8;
`else
        exp_snap = 10;
`endif
        for (int c = 0; c < 50; c++) begin
            bus.io_wr = ((c % 3) == 0) && (c < 30);
            bus.io_a  = AW'(32'h300 + c);
            bus.io_d  = 8'(c);
            if (c == 1) begin
                bus.cpu_req = 1'b1;
                bus.cpu_we  = 1'b0;
                bus.cpu_a   = AW'(32'h55);
            end
            tick();
            if (ack_prev) bus.cpu_req = 1'b0;
            ack_prev = bus.cpu_ack;
        end
        bus.io_wr = 1'b0;
        chk("fair_one_ack",    64'(n_ack - acks0),       64'd1);
        chk("fair_ack_writes", 64'(ack_wsnap - base),    64'(exp_snap));
        chk("fair_cpu_q",      64'(bus.cpu_q),           64'h11);
        chk("fair_nwrites",    64'(wq.size() - base),    64'd10);
        e = {AW'(32'h300 + 27), 8'(27)};
        chk("fair_last_entry", 64'(wq[base + 9]),        64'(e));

        // ---- reset in the middle of a CPU write
        acks0       = n_ack;
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_a   = AW'(32'h1234);
        bus.cpu_d   = 8'h77;
        tick();                                   // first cycle of the write
        chk("rstmid_we", 64'(bus.ram_we), 64'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("rstmid");
        tick();
        tick();
        chk("rstmid_no_ack", 64'(n_ack - acks0), 64'd0);
        reset = 1'b0;                             // first IDLE cycle
        tick();
        chk("rerun_we_t1", 64'(bus.ram_we), 64'd1);
        chk("rerun_a_t1",  64'(bus.ram_a),  64'h1234);
        chk("rerun_d_t1",  64'(bus.ram_d),  64'h77);
        tick();
        chk("rerun_we_t2",  64'(bus.ram_we),  64'd1);
        chk("rerun_ack_t2", 64'(bus.cpu_ack), 64'd0);
        tick();
        chk("rerun_ack_t3", 64'(bus.cpu_ack), 64'd1);
        chk("rerun_we_t3",  64'(bus.ram_we),  64'd0);
        tick();
        bus.cpu_req = 1'b0;
        tick();
        chk("rerun_one_ack", 64'(n_ack - acks0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
